lzc_renorm_arbiter: RTL

Two-lane scheduler that shares one 16-bit leading-zero counter (`lzc_miao_16`) between two boolean-encoder lanes for range renormalization. Each lane offers a 16-bit range value over a valid/ready handshake; the block arbitrates round-robin, computes the shift `d`, the normalized range and per-lane pending-bit bookkeeping in a 2-stage pipeline, and returns lane-tagged results under output backpressure. It sits between the per-lane range-update logic and the low/byte-output stage of the entropy encoder.

---
 rtl/lzc_renorm_arbiter_pkg.sv | 18 +
 rtl/lzc_renorm_arbiter_lzc.sv | 20 ++
 rtl/lzc_renorm_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/lzc_renorm_arbiter_pkg.sv
// Shared constants and payload types for the two-lane LZC renormalization arbiter.
package lzc_renorm_arbiter_pkg;

  localparam int unsigned LANES = 2;
  localparam int unsigned RNG_W = 16;
  localparam int unsigned D_W   = 4;
  localparam int unsigned ACC_W = 3;
  localparam int unsigned SUM_W = 5;
  localparam int unsigned BYT_W = SUM_W - ACC_W;

  typedef logic lane_t;

  typedef struct packed {
    lane_t            lane;
    logic [RNG_W-1:0] rng;
  } s1_t;

endpackage

// File: rtl/lzc_renorm_arbiter_lzc.sv
// 16-bit leading-zero counter; zero input reports d=0 with zero_c set.
module lzc_miao_16
  import lzc_renorm_arbiter_pkg::*;
(
  input  logic [RNG_W-1:0] rng,
  output logic [D_W-1:0]   d_c,
  output logic             zero_c
);

  // Ascending scan: the highest set bit is the last one to write d_c.
  always_comb begin
    d_c = '0;
    for (int i = 0; i < int'(RNG_W); i++) begin
      if (rng[i]) d_c = D_W'(int'(RNG_W) - 1 - i);
    end
  end

  assign zero_c = ~|rng;

endmodule

// File: rtl/lzc_renorm_arbiter.sv
// Round-robin two-lane front end sharing one LZC, with a 2-stage pipeline
// producing shift, normalized range and per-lane byte/bit accumulation.
module lzc_renorm_arbiter
  import lzc_renorm_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] req_valid,
  input  logic [WIDTH-1:0] req_rng0,
  input  logic [WIDTH-1:0] req_rng1,
  output logic [LANES-1:0] req_ready,
  input  logic [LANES-1:0] acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lane,
  output logic [D_W-1:0]   out_d,
  output logic [WIDTH-1:0] out_rng,
  output logic             out_zero,
  output logic [BYT_W-1:0] out_bytes,
  output logic [ACC_W-1:0] out_acc
);

  lane_t            rr;
  logic             s1_valid;
  s1_t              s1;
  logic [ACC_W-1:0] acc [LANES];

  logic [LANES-1:0] grant_c;
  logic             s2_adv_c;
  logic             s1_load_c;
  logic             xfer_c;
  lane_t            gnt_lane_c;
  logic [D_W-1:0]   lzc_d_c;
  logic             lzc_zero_c;
  logic [ACC_W-1:0] base_c;
  logic [SUM_W-1:0] sum_c;

  // Round-robin grant: rr wins a tie, otherwise the single requester.
  always_comb begin
    grant_c = req_valid;
    if (&req_valid) grant_c = {rr, ~rr};
  end

  assign s2_adv_c   = s1_valid & (~out_valid | out_ready);
  assign s1_load_c  = ~s1_valid | s2_adv_c;
  assign req_ready  = grant_c & {LANES{s1_load_c & rst_n}};
  assign xfer_c     = |(req_valid & req_ready);
  assign gnt_lane_c = req_ready[1];

  lzc_miao_16 u_lzc (
    .rng    (s1.rng),
    .d_c    (lzc_d_c),
    .zero_c (lzc_zero_c)
  );

  // Zero input yields d=0, so the sum degenerates to the (possibly cleared) base.
  always_comb begin
    base_c = acc_clr[s1.lane] ? '0 : acc[s1.lane];
    sum_c  = SUM_W'(base_c) + SUM_W'(lzc_d_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= 1'b0;
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      if (xfer_c) rr <= ~gnt_lane_c;
      if (s1_load_c) begin
        s1_valid <= xfer_c;
        if (xfer_c) begin
          s1.lane <= gnt_lane_c;
          s1.rng  <= gnt_lane_c ? RNG_W'(req_rng1) : RNG_W'(req_rng0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LANES); i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (s2_adv_c && (s1.lane == lane_t'(i))) acc[i] <= sum_c[ACC_W-1:0];
        else if (acc_clr[i])                     acc[i] <= '0;
      end
    end
  end

  // Output stage doubles as the second buffer slot; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_lane  <= 1'b0;
      out_d     <= '0;
      out_rng   <= '0;
      out_zero  <= 1'b0;
      out_bytes <= '0;
      out_acc   <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_lane  <= s1.lane;
        out_d     <= lzc_d_c;
        out_rng   <= WIDTH'(s1.rng << lzc_d_c);
        out_zero  <= lzc_zero_c;
        out_bytes <= sum_c[SUM_W-1:ACC_W];
        out_acc   <= sum_c[ACC_W-1:0];
      end
    end
  end

endmodule
